// File: rtl/uart_pkg.sv
// Shared types, width helper and ASCII constants for the UART transmit path
// and the message sequencer that feeds it.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // Minimum 1-bit width so that degenerate sizes still give legal vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/uart_tx_path_if.sv
// Push/status bundle between the message sequencer (master) and the UART
// transmit path (slave).
interface uart_tx_path_if;
  logic       tx_push;
  logic [7:0] tx_push_data;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_overflow;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  modport master (
    output tx_push, tx_push_data,
    input  tx_full, tx_empty, tx_overflow, tx_busy, tx_done, tx
  );

  modport slave (
    input  tx_push, tx_push_data,
    output tx_full, tx_empty, tx_overflow, tx_busy, tx_done, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a registered occupancy count; pushes into a
// full FIFO are dropped and flagged on overflow in the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = idx_width(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A push while full is refused even if a pop frees a slot this cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign overflow = push && full;
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_path.sv
// 8N1 UART transmitter fed from a small FIFO; one idle-high load cycle
// separates back-to-back frames.
//
//   state | meaning
//   IDLE  | line high, pop head byte when FIFO not empty
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high), tx_done in its last cycle
module uart_tx_path
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  uart_tx_path_if.slave bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int BW = idx_width(BIT_CYCLES);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BAUD_PREV = BW'(BIT_CYCLES - 2);

  uart_tx_state_t state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     head;
  logic           fifo_empty;
  logic           pop;
  logic           tx_q;
  logic           done_q;

  assign pop = (state == IDLE) && !fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.tx_push),
    .push_data (bus.tx_push_data),
    .pop       (pop),
    .rdata     (head),
    .full      (bus.tx_full),
    .empty     (fifo_empty),
    .overflow  (bus.tx_overflow)
  );

  assign bus.tx_empty = fifo_empty;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx       = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift    <= head;
            baud_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
            // Registered pulse lands on the final stop-bit cycle.
            if (baud_cnt == BAUD_PREV) done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_path.sv
// Directed bench for uart_tx_path: a line receiver decodes frames and the
// main thread compares them with hand-computed bytes and cycle numbers.
module tb_uart_tx_path;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 8;
  localparam int BITC     = 16;

  logic clk = 1'b0;
  logic reset;

  uart_tx_path_if bus();

  uart_tx_path #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor and receiver, sampling mid-cycle on the falling edge.
  int         ovf_cnt  = 0;
  int         ovf_cyc  = -1;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         full_cnt = 0;
  bit         rx_active = 1'b0;
  int         rx_cnt;
  int         rx_start;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_stop[$];

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (bus.tx_overflow) begin ovf_cnt++; ovf_cyc = cyc; end
      if (bus.tx_done)     begin done_cnt++; done_cyc = cyc; end
      if (bus.tx_full)     full_cnt++;
      if (!rx_active) begin
        if (bus.tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_start  = cyc;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= 8 + BITC && rx_cnt <= 8 + 8 * BITC && (rx_cnt - 8) % BITC == 0)
          rx_sh = {bus.tx, rx_sh[7:1]};
        if (rx_cnt == 8 + 9 * BITC) begin
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_start);
          rx_stop.push_back(bus.tx);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    step();
    while (!(bus.tx_empty && !bus.tx_busy) && k < limit) begin
      step();
      k++;
    end
    check(tag, 32'(k < limit), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] msg [7] = '{8'h71, 8'h73, 8'h74, 8'h69, 8'h63, 8'h6B, 8'h0A};
  logic [7:0] s5   [11] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                            8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};

  initial begin
    int n0;
    int base;
    int d0;
    int o0;
    int f0;
    int low_seen;

    reset             = 1'b1;
    bus.tx_push       = 1'b0;
    bus.tx_push_data  = 8'h00;

    // 1: reset held, outputs {tx,empty,full,busy,done,overflow}
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_outputs",
            {26'd0, bus.tx, bus.tx_empty, bus.tx_full, bus.tx_busy, bus.tx_done, bus.tx_overflow},
            32'b110000);
    end
    reset = 1'b0;
    repeat (2) step();

    // 2: single byte 0x71, exact cycle timing
    base = rx_q.size();
    d0   = done_cnt;
    n0   = cyc;
    bus.tx_push      = 1'b1;
    bus.tx_push_data = 8'h71;
    step();
    bus.tx_push = 1'b0;
    bus.tx_push_data = 8'hFF;
    check("s2_n1_tx", bus.tx, 1'b1);
    check("s2_n1_empty", bus.tx_empty, 1'b0);
    step();
    check("s2_n2_tx", bus.tx, 1'b0);
    check("s2_n2_busy", bus.tx_busy, 1'b1);
    check("s2_n2_empty", bus.tx_empty, 1'b1);
    for (int i = 0; i < 200 && cyc < n0 + 161; i++) step();
    check("s2_done_at_161", bus.tx_done, 1'b1);
    check("s2_busy_at_161", bus.tx_busy, 1'b1);
    step();
    check("s2_busy_at_162", bus.tx_busy, 1'b0);
    check("s2_done_at_162", bus.tx_done, 1'b0);
    repeat (3) step();
    check("s2_frames", 32'(rx_q.size() - base), 32'd1);
    if (rx_q.size() > base) begin
      check("s2_byte", rx_q[base], 8'h71);
      check("s2_start_cycle", 32'(rx_t[base] - n0), 32'd2);
      check("s2_stop_bit", rx_stop[base], 1'b1);
    end
    check("s2_done_count", 32'(done_cnt - d0), 32'd1);
    check("s2_done_cycle", 32'(done_cyc - n0), 32'd161);

    // 3: "qstick\n" back to back
    base = rx_q.size();
    f0   = full_cnt;
    n0   = cyc;
    for (int i = 0; i < 7; i++) begin
      bus.tx_push      = 1'b1;
      bus.tx_push_data = msg[i];
      step();
    end
    bus.tx_push = 1'b0;
    wait_idle("s3_idle_timeout", 2000);
    check("s3_frames", 32'(rx_q.size() - base), 32'd7);
    if (rx_q.size() >= base + 7) begin
      check("s3_first_start", 32'(rx_t[base] - n0), 32'd2);
      for (int i = 0; i < 7; i++) begin
        check("s3_byte", rx_q[base + i], msg[i]);
        check("s3_stop_bit", rx_stop[base + i], 1'b1);
        if (i > 0) check("s3_spacing", 32'(rx_t[base + i] - rx_t[base + i - 1]), 32'd161);
      end
    end
    check("s3_full_never", 32'(full_cnt - f0), 32'd0);

    // 4: overflow on the tenth push
    base = rx_q.size();
    o0   = ovf_cnt;
    n0   = cyc;
    for (int i = 0; i < 10; i++) begin
      bus.tx_push      = 1'b1;
      bus.tx_push_data = 8'(i);
      if (i == 8) check("s4_not_full_at_byte8", bus.tx_full, 1'b0);
      if (i == 9) check("s4_full_at_byte9", bus.tx_full, 1'b1);
      step();
    end
    bus.tx_push = 1'b0;
    check("s4_ovf_count", 32'(ovf_cnt - o0), 32'd1);
    check("s4_ovf_cycle", 32'(ovf_cyc - n0), 32'd9);
    wait_idle("s4_idle_timeout", 3000);
    check("s4_frames", 32'(rx_q.size() - base), 32'd9);
    if (rx_q.size() >= base + 9)
      for (int i = 0; i < 9; i++) check("s4_byte", rx_q[base + i], 8'(i));

    // 5: pointer wrap across two bursts
    base = rx_q.size();
    f0   = full_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.tx_push      = 1'b1;
      bus.tx_push_data = s5[i];
      step();
    end
    bus.tx_push = 1'b0;
    wait_idle("s5a_idle_timeout", 2000);
    check("s5_empty_mid", bus.tx_empty, 1'b1);
    for (int i = 5; i < 11; i++) begin
      bus.tx_push      = 1'b1;
      bus.tx_push_data = s5[i];
      step();
    end
    bus.tx_push = 1'b0;
    wait_idle("s5b_idle_timeout", 2000);
    check("s5_frames", 32'(rx_q.size() - base), 32'd11);
    if (rx_q.size() >= base + 11)
      for (int i = 0; i < 11; i++) check("s5_byte", rx_q[base + i], s5[i]);
    check("s5_full_never", 32'(full_cnt - f0), 32'd0);
    check("s5_empty_end", bus.tx_empty, 1'b1);

    // 6: reset during data bit 3 of the first of three queued bytes
    base = rx_q.size();
    n0   = cyc;
    for (int i = 0; i < 3; i++) begin
      bus.tx_push      = 1'b1;
      bus.tx_push_data = 8'hC1 + 8'(i);
      step();
    end
    bus.tx_push = 1'b0;
    for (int i = 0; i < 200 && cyc < n0 + 70; i++) step();
    check("s6_busy_before_reset", bus.tx_busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s6_tx_after_reset", bus.tx, 1'b1);
    check("s6_empty_after_reset", bus.tx_empty, 1'b1);
    check("s6_busy_after_reset", bus.tx_busy, 1'b0);
    low_seen = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.tx !== 1'b1) low_seen++;
    end
    check("s6_line_quiet", 32'(low_seen), 32'd0);
    check("s6_no_frames", 32'(rx_q.size() - base), 32'd0);
    bus.tx_push      = 1'b1;
    bus.tx_push_data = 8'h5A;
    step();
    bus.tx_push = 1'b0;
    wait_idle("s6_idle_timeout", 400);
    check("s6_frames_after", 32'(rx_q.size() - base), 32'd1);
    if (rx_q.size() > base) check("s6_byte_after", rx_q[base], 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
